// File: rtl/sincos_lut_seq.sv
// Handshaked sin/cos lookup: folds a signed degree angle into [0,360) and reads a shared quarter-wave ROM.
// Define SINCOS_COS_EN to add the cosine read; otherwise cos_out is tied to zero and latency drops by one.
module sincos_lut_seq #(
    parameter int ANG_W     = 16,
    parameter int OUT_W     = 16,
    parameter int ROM_DEPTH = 64,
    parameter int ROM_W     = 8,
    parameter     ROM_FILE  = "sin_table_64x8.hex"
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [ANG_W-1:0] in_angle,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [OUT_W-1:0] sin_out,
    output logic signed [OUT_W-1:0] cos_out,
    output logic                    busy
);

    localparam int ADDR_W = $clog2(ROM_DEPTH);
    localparam logic signed [ANG_W:0] DEG360 = (ANG_W+1)'(360);

    typedef enum logic [2:0] {IDLE, NORM, RD_SIN, RD_COS, CAP, HOLD} state_t;

    state_t                  state, next_state;
    logic signed [ANG_W:0]   theta;
    logic [ADDR_W-1:0]       rom_addr;
    logic [ROM_W-1:0]        rom_data;
    logic [ROM_W-1:0]        rom [ROM_DEPTH];
    logic signed [OUT_W-1:0] sin_q;
    logic                    ld_sin;
    int                      theta_i;
    logic [ADDR_W-1:0]       sin_idx;
    logic                    sin_neg;

    // Table contents are generated at elaboration with the same formula used to build ROM_FILE.
    function automatic int sin_entry(input int k);
        real x, term, acc;
        x    = 3.14159265358979 * real'(k) / (2.0 * real'(ROM_DEPTH));
        term = x;
        acc  = x;
        for (int unsigned n = 1; n < 12; n++) begin
            term = -term * x * x / real'((2 * n) * (2 * n + 1));
            acc  = acc + term;
        end
        return $rtoi(acc * real'((1 << ROM_W) - 1) + 0.5);
    endfunction

    function automatic logic [ADDR_W-1:0] rom_idx(input int a);
        int f, i;
        if (a < 90)       f = a;
        else if (a < 180) f = 180 - a;
        else if (a < 270) f = a - 180;
        else              f = 360 - a;
        i = (ROM_DEPTH * f) / 90;
        if (i > ROM_DEPTH - 1) i = ROM_DEPTH - 1;
        return ADDR_W'(i);
    endfunction

    function automatic logic signed [OUT_W-1:0] apply_sign(input logic [ROM_W-1:0] mag,
                                                           input logic neg);
        logic signed [OUT_W-1:0] ext;
        ext = {{(OUT_W-ROM_W){1'b0}}, mag};
        return neg ? -ext : ext;
    endfunction

    for (genvar k = 0; k < ROM_DEPTH; k++) begin : g_rom
        localparam logic [ROM_W-1:0] ENTRY = ROM_W'(sin_entry(k));
        assign rom[k] = ENTRY;
    end

    always_ff @(posedge clk) rom_data <= rom[rom_addr];

`ifdef SINCOS_COS_EN
    logic signed [OUT_W-1:0] cos_q;
    logic                    ld_cos;
    int                      theta_c;
    logic [ADDR_W-1:0]       cos_idx;
    logic                    cos_neg;

    always_comb begin
        theta_c = theta_i + 90;
        if (theta_c >= 360) theta_c = theta_c - 360;
        cos_idx = rom_idx(theta_c);
        cos_neg = (theta_c > 180);
    end
    assign cos_out = cos_q;
`else
    assign cos_out = '0;
`endif

    always_comb begin
        theta_i = int'(theta);
        sin_idx = rom_idx(theta_i);
        sin_neg = (theta_i > 180);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        rom_addr   = sin_idx;
        ld_sin     = 1'b0;
`ifdef SINCOS_COS_EN
        ld_cos     = 1'b0;
`endif
        case (state)
            IDLE:   if (in_valid && in_ready) next_state = NORM;
            NORM:   if (!(theta >= DEG360) && !theta[ANG_W]) next_state = RD_SIN;
`ifdef SINCOS_COS_EN
            RD_SIN: next_state = RD_COS;
            RD_COS: begin
                ld_sin     = 1'b1;
                rom_addr   = cos_idx;
                next_state = CAP;
            end
            CAP: begin
                ld_cos     = 1'b1;
                next_state = HOLD;
            end
`else
            RD_SIN: next_state = CAP;
            CAP: begin
                ld_sin     = 1'b1;
                next_state = HOLD;
            end
`endif
            HOLD:   if (out_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // in_ready/out_valid are registered from next_state so both change on the same edge as the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            theta     <= '0;
            sin_q     <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            in_ready  <= (next_state == IDLE);
            out_valid <= (next_state == HOLD);
            if (state == IDLE && in_valid && in_ready)
                theta <= {in_angle[ANG_W-1], in_angle};
            else if (state == NORM) begin
                if (theta >= DEG360)    theta <= theta - DEG360;
                else if (theta[ANG_W])  theta <= theta + DEG360;
            end
            if (ld_sin) sin_q <= apply_sign(rom_data, sin_neg);
        end
    end

`ifdef SINCOS_COS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      cos_q <= '0;
        else if (ld_cos) cos_q <= apply_sign(rom_data, cos_neg);
    end
`endif

    assign sin_out = sin_q;
    assign busy    = (state != IDLE);

endmodule

// File: doc/sincos_lut_seq.md
Name: sincos_lut_seq

Overview:
- Sequential, handshaked successor of the combinational sine lookup.
- Accepts a signed integer angle in degrees and folds it into [0,360) over multiple cycles.
- Reads one shared quarter-wave ROM twice, once for sin and once for cos (cos(θ) = sin(θ+90)).
- Returns correctly signed two's-complement sin/cos values. Feeds the rotation-matrix stage of the 3D transform pipeline.

Parameters:
- ANG_W, 16, signed input angle width (degrees).
- OUT_W, 16, signed output width; must be ≥ ROM_W+1.
- ROM_DEPTH, 64, quarter-wave entries covering 0..90°.
- ROM_W, 8, unsigned magnitude width per entry.
- ROM_FILE, "sin_table_64x8.hex", $readmemh init file.
  - Entry k = round((2^ROM_W−1)·sin(k·π/(2·ROM_DEPTH))).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  angle request valid.
- in_ready  out  1  block idle; request accepted when in_valid&in_ready at a rising edge.
- in_angle  in  ANG_W  signed angle, degrees.
- out_valid  out  1  result valid; held until taken.
- out_ready  in  1  consumer accepts result.
- sin_out  out  OUT_W  signed sin result.
- cos_out  out  OUT_W  signed cos result.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Clock and reset: single clock clk; reset asynchronous, active-low (rst_n).
- Reset values: state IDLE; in_ready 0, rising to 1 on the first clk after rst_n deasserts; out_valid 0; sin_out 0; cos_out 0; busy 0.
- Reset asserted mid-operation: aborts immediately, emits no result, all outputs take reset values.
- ROM: synchronous read, registered address, data available one cycle later. Only one ROM instance exists.
- Fold of θ ∈ [0,360) to a ROM address:
  - [0,90): f = θ
  - [90,180): f = 180−θ
  - [180,270): f = θ−180
  - [270,360): f = 360−θ
  - idx = (ROM_DEPTH·f)/90 using integer truncation, clamped to ROM_DEPTH−1 (so f = 90 → idx 63).
- Signs:
  - sin is negative for θ ∈ (180,360).
  - cos is computed as sin(θc), θc = θ+90, wrapped by −360 if θc ≥ 360.
  - Output = zero-extended magnitude, two's-complement negated when negative. No unsigned-multiply-by-−1 artefacts.
- FSM:
  - IDLE: in_ready=1. On accept, latch in_angle sign-extended to ANG_W+1 bits into θ; go to NORM.
  - NORM: one step per cycle.
    - If θ ≥ 360, θ −= 360.
    - Else if θ < 0, θ += 360.
    - Else go to RD_SIN.
    - Cycles spent = 1 + number of 360° corrections.
  - RD_SIN: drive the sin address; go to RD_COS.
  - RD_COS: capture sin_out from ROM data and sign; drive the cos address; go to CAP.
  - CAP: capture cos_out; set out_valid; go to HOLD.
  - HOLD: out_valid=1; sin_out and cos_out stable. On out_valid&out_ready go to IDLE and drop out_valid.
- Latency: for in_angle ∈ [0,360), out_valid is first high 4 clk edges after the accept edge. Add 1 edge per 360° correction.
- Back-pressure: out_ready may stay low indefinitely; the result is held.
- Re-accept: no accept in the same cycle as a handshake out. in_ready rises the cycle after IDLE is entered.
- Result persistence: sin_out and cos_out retain their last values after handshake until the next capture.
- in_valid outside IDLE is ignored and not queued.

Optional Feature:
- Macro: SINCOS_COS_EN.
- Defined: behaviour as above.
- Undefined:
  - RD_COS is omitted; RD_SIN goes directly to CAP, which captures sin.
  - cos_out is tied 0.
  - Latency is reduced by 1 (3 edges for in-range angles).

Test Plan:
- Reset released, in_angle=0 accepted → in_ready low during processing; after 4 edges out_valid=1, sin_out=0, cos_out=255 (idx 63, clamped).
- in_angle=30 → sin_out=126 (idx 21), cos_out=219 (θc=120, fold 60, idx 42).
- in_angle=210 → sin_out=−126, cos_out=−219 (0xFF82, 0xFF25 at OUT_W=16).
- Wrap handling:
  - in_angle=−90 → one correction; out_valid after 5 edges; sin_out=−255, cos_out=0.
  - in_angle=810 → two corrections; sin_out=255, cos_out=0.
- Back-pressure: out_ready held low 10 cycles → out_valid and outputs stable, in_valid pulses ignored; then out_ready=1 → out_valid drops, in_ready=1 next cycle.
- rst_n pulsed low during NORM of in_angle=720 → outputs zero immediately, no out_valid; next request (in_angle=90) gives sin_out=255, cos_out=0.
